board_state_mem: RTL and testbench

- Owns the 8x8 chess board state: one 4-bit piece code per square.
- Serves two combinational read ports:
  - the render port (view_x/view_y -> piece_read) polled by the board renderer while it draws squares;
  - a logic port used by game/move logic.
- Executes move commands (src -> dst, clear src) through a handshake, and reloads the starting position on reset or new_game.

---
 rtl/board_state_mem.sv | 205 ++++++++++++++++++++
 tb/tb_board_state_mem.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_state_mem.sv
// board_state_mem: 8x8 chess board store, one 4-bit piece code per square.
// It has two combinational read ports (render and game logic) and a small
// controller. The controller reloads the starting position one square per
// cycle and runs three-step moves: read, write the destination, clear the
// source.
module board_state_mem #(
   parameter int INIT_CYCLES = 64
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic [2:0] view_x,
   input  logic [2:0] view_y,
   output logic [3:0] piece_read,
   input  logic [2:0] logic_x,
   input  logic [2:0] logic_y,
   output logic [3:0] logic_piece,
   input  logic       new_game,
   input  logic       move_req,
   input  logic [2:0] src_x,
   input  logic [2:0] src_y,
   input  logic [2:0] dst_x,
   input  logic [2:0] dst_y,
   output logic       ready,
   output logic       move_done,
   output logic [3:0] captured
);

   typedef enum logic [2:0] {
      S_FILL       = 3'd0,
      S_IDLE       = 3'd1,
      S_MOVE_READ  = 3'd2,
      S_MOVE_WRITE = 3'd3,
      S_MOVE_CLEAR = 3'd4
   } state_t;

   localparam logic [5:0] FILL_LAST = 6'(INIT_CYCLES - 1);

   // Starting position for a square address (y*8 + x). The black pieces use
   // the white code plus 6, so the back rank is described once.
   function automatic logic [3:0] start_piece(input logic [5:0] addr);
      logic [3:0] back;
      logic [3:0] code;
      case (addr[2:0])
         3'd0, 3'd7: back = 4'd5;   // rook
         3'd1, 3'd6: back = 4'd8;   // knight
         3'd2, 3'd5: back = 4'd6;   // bishop
         3'd3:       back = 4'd4;   // queen
         default:    back = 4'd3;   // king
      endcase
      case (addr[5:3])
         3'd0:    code = back + 4'd6;
         3'd1:    code = 4'd13;
         3'd6:    code = 4'd7;
         3'd7:    code = back;
         default: code = 4'd0;
      endcase
      return code;
   endfunction

   state_t     state_q, state_d;
   logic [5:0] fill_addr_q, fill_addr_d;
   logic [5:0] src_q, src_d;
   logic [5:0] dst_q, dst_d;
   logic [3:0] mv_piece_q, mv_piece_d;
   logic [3:0] captured_q, captured_d;
   logic       move_done_q, move_done_d;

   // Single shared write port into the square array
   logic       wr_en;
   logic [5:0] wr_addr;
   logic [3:0] wr_data;

   logic [3:0] board [64];

   // One register per square. A write at an edge shows up on the reads right after it.
   genvar gi;
   generate
      for (gi = 0; gi < 64; gi++) begin : g_sq
         logic [3:0] sq_q, sq_d;

         // Load the shared write data when this square is addressed
         always_comb begin
            sq_d = sq_q;
            if (wr_en && (wr_addr == 6'(gi))) begin
               sq_d = wr_data;
            end
         end

         // Square storage has no reset; the fill sequence rewrites it
         always_ff @(posedge clk) begin
            sq_q <= sq_d;
         end

         assign board[gi] = sq_q;
      end
   endgenerate

   // Both read ports are plain muxes over the array
   assign piece_read  = board[{view_y, view_x}];
   assign logic_piece = board[{logic_y, logic_x}];

   assign ready     = (state_q == S_IDLE);
   assign move_done = move_done_q;
   assign captured  = captured_q;

   // Write-port select: fill square, move destination, or clear of the source.
   // Suppressed while reset is asserted so an interrupted move cannot land.
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = 6'd0;
      wr_data = 4'd0;
      if (resetn) begin
         case (state_q)
            S_FILL: begin
               wr_en   = 1'b1;
               wr_addr = fill_addr_q;
               wr_data = start_piece(fill_addr_q);
            end
            S_MOVE_WRITE: begin
               wr_en   = 1'b1;
               wr_addr = dst_q;
               wr_data = mv_piece_q;
            end
            S_MOVE_CLEAR: begin
               wr_en   = 1'b1;
               wr_addr = src_q;
               wr_data = 4'd0;
            end
            default: begin
               wr_en = 1'b0;
            end
         endcase
      end
   end

   // Next-state logic for the fill/move controller
   always_comb begin
      state_d     = state_q;
      fill_addr_d = fill_addr_q;
      src_d       = src_q;
      dst_d       = dst_q;
      mv_piece_d  = mv_piece_q;
      captured_d  = captured_q;
      move_done_d = 1'b0;
      case (state_q)
         S_FILL: begin
            if (fill_addr_q == FILL_LAST) begin
               fill_addr_d = 6'd0;
               state_d     = S_IDLE;
            end else begin
               fill_addr_d = fill_addr_q + 6'd1;
            end
         end
         S_IDLE: begin
            // new_game has priority; a move offered in the same cycle is dropped
            if (new_game) begin
               fill_addr_d = 6'd0;
               state_d     = S_FILL;
            end else if (move_req) begin
               src_d   = {src_y, src_x};
               dst_d   = {dst_y, dst_x};
               state_d = S_MOVE_READ;
            end
         end
         S_MOVE_READ: begin
            mv_piece_d = board[src_q];
            captured_d = board[dst_q];
            state_d    = S_MOVE_WRITE;
         end
         S_MOVE_WRITE: begin
            state_d = S_MOVE_CLEAR;
         end
         S_MOVE_CLEAR: begin
            // The clear comes after the write, so src == dst leaves the square empty
            move_done_d = 1'b1;
            state_d     = S_IDLE;
         end
         default: begin
            state_d = S_FILL;
         end
      endcase
   end

   // Controller registers; reset restarts the fill and abandons any move
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q     <= S_FILL;
         fill_addr_q <= 6'd0;
         src_q       <= 6'd0;
         dst_q       <= 6'd0;
         mv_piece_q  <= 4'd0;
         captured_q  <= 4'd0;
         move_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         fill_addr_q <= fill_addr_d;
         src_q       <= src_d;
         dst_q       <= dst_d;
         mv_piece_q  <= mv_piece_d;
         captured_q  <= captured_d;
         move_done_q <= move_done_d;
      end
   end

endmodule

// File: tb/tb_board_state_mem.sv
// Testbench for board_state_mem. A square-indexed model array holds the
// board, moves are applied by the rules of a chess move, and random moves
// are checked against that model.
module tb_board_state_mem;

   logic       clk;
   logic       resetn;
   logic [2:0] view_x, view_y, logic_x, logic_y;
   logic [3:0] piece_read, logic_piece;
   logic       new_game, move_req;
   logic [2:0] src_x, src_y, dst_x, dst_y;
   logic       ready, move_done;
   logic [3:0] captured;

   int errors;
   int checks;
   int model [64];
   int done_pulses;

   board_state_mem #(.INIT_CYCLES(64)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .view_x     (view_x),
      .view_y     (view_y),
      .piece_read (piece_read),
      .logic_x    (logic_x),
      .logic_y    (logic_y),
      .logic_piece(logic_piece),
      .new_game   (new_game),
      .move_req   (move_req),
      .src_x      (src_x),
      .src_y      (src_y),
      .dst_x      (dst_x),
      .dst_y      (dst_y),
      .ready      (ready),
      .move_done  (move_done),
      .captured   (captured)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count move_done pulses away from the active edge
   always @(negedge clk) begin
      if (move_done === 1'b1) done_pulses++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1, "watchdog");
   end

   // Starting position from the chess rules.
   function automatic int start_code(int x, int y);
      int back [8];
      back = '{5, 8, 6, 4, 3, 6, 8, 5};
      if (y == 7) return back[x];
      if (y == 6) return 7;
      if (y == 1) return 13;
      if (y == 0) return back[x] + 6;
      return 0;
   endfunction

   task automatic model_load_start();
      for (int i = 0; i < 64; i++) model[i] = start_code(i % 8, i / 8);
   endtask

   // Wait (bounded) until ready goes high; n = number of edges waited
   task automatic wait_ready(output int n);
      n = 0;
      while (ready !== 1'b1 && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   // Full-board comparison of both read ports against the model
   task automatic sweep_board(input string tag);
      for (int i = 0; i < 64; i++) begin
         view_x  = 3'(i % 8);
         view_y  = 3'(i / 8);
         logic_x = 3'(7 - (i % 8));
         logic_y = 3'(7 - (i / 8));
         #1;
         checks++;
         if (piece_read !== 4'(model[i])) begin
            errors++;
            $display("FAIL %s render sq%0d: got %0d expected %0d", tag, i, piece_read, model[i]);
         end
         checks++;
         if (logic_piece !== 4'(model[63 - i])) begin
            errors++;
            $display("FAIL %s logic sq%0d: got %0d expected %0d", tag, 63 - i, logic_piece, model[63 - i]);
         end
      end
   endtask

   // Issue one move, check the handshake timing cycle by cycle, then the board
   task automatic run_move(input int sx, input int sy, input int dx, input int dy);
      int exp_cap;
      int d0;
      int s, d;
      s = sy * 8 + sx;
      d = dy * 8 + dx;
      exp_cap = model[d];
      @(posedge clk); #1;
      checks++;
      if (ready !== 1'b1) begin
         errors++;
         $display("FAIL move_pre_ready: got %0b expected 1", ready);
      end
      src_x = 3'(sx); src_y = 3'(sy); dst_x = 3'(dx); dst_y = 3'(dy);
      move_req = 1'b1;
      @(posedge clk); #1;
      move_req = 1'b0;
      d0 = done_pulses;
      for (int k = 0; k <= 4; k++) begin
         checks++;
         if (move_done !== (k == 3)) begin
            errors++;
            $display("FAIL move_done k=%0d: got %0b expected %0b", k, move_done, (k == 3));
         end
         checks++;
         if (ready !== (k >= 3)) begin
            errors++;
            $display("FAIL move_ready k=%0d: got %0b expected %0b", k, ready, (k >= 3));
         end
         if (k == 3) begin
            checks++;
            if (captured !== 4'(exp_cap)) begin
               errors++;
               $display("FAIL move_captured (%0d,%0d)->(%0d,%0d): got %0d expected %0d",
                        sx, sy, dx, dy, captured, exp_cap);
            end
         end
         if (k < 4) begin
            @(posedge clk); #1;
         end
      end
      checks++;
      if (done_pulses - d0 != 1) begin
         errors++;
         $display("FAIL move_pulse_count: got %0d expected 1", done_pulses - d0);
      end
      model[d] = model[s];
      model[s] = 0;
      $display("move (%0d,%0d)->(%0d,%0d) captured=%0d", sx, sy, dx, dy, exp_cap);
      sweep_board("move");
   endtask

   task automatic test_reset();
      int n;
      resetn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0b expected 0", ready); end
      checks++;
      if (move_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", move_done); end
      checks++;
      if (captured !== 4'd0) begin errors++; $display("FAIL reset_captured: got %0d expected 0", captured); end
      resetn = 1'b1;
      wait_ready(n);
      checks++;
      if (n != 64) begin errors++; $display("FAIL reset_fill_cycles: got %0d expected 64", n); end
      $display("reset fill cycles=%0d", n);
      model_load_start();
      sweep_board("start");
      // Spot checks straight from the starting-position rules
      view_x = 3; view_y = 0; #1; checks++;
      if (piece_read !== 4'd10) begin errors++; $display("FAIL start_3_0: got %0d expected 10", piece_read); end
      view_x = 4; view_y = 7; #1; checks++;
      if (piece_read !== 4'd3) begin errors++; $display("FAIL start_4_7: got %0d expected 3", piece_read); end
      view_x = 0; view_y = 1; #1; checks++;
      if (piece_read !== 4'd13) begin errors++; $display("FAIL start_0_1: got %0d expected 13", piece_read); end
      view_x = 5; view_y = 6; #1; checks++;
      if (piece_read !== 4'd7) begin errors++; $display("FAIL start_5_6: got %0d expected 7", piece_read); end
      view_x = 2; view_y = 4; #1; checks++;
      if (piece_read !== 4'd0) begin errors++; $display("FAIL start_2_4: got %0d expected 0", piece_read); end
   endtask

   task automatic test_quiet_move();
      run_move(4, 6, 4, 4);
      view_x = 4; view_y = 4; #1; checks++;
      if (piece_read !== 4'd7) begin errors++; $display("FAIL quiet_dst: got %0d expected 7", piece_read); end
      view_x = 4; view_y = 6; #1; checks++;
      if (piece_read !== 4'd0) begin errors++; $display("FAIL quiet_src: got %0d expected 0", piece_read); end
   endtask

   task automatic test_capture();
      run_move(3, 7, 3, 1);
      logic_x = 3; logic_y = 1; view_x = 3; view_y = 1; #1; checks++;
      if (logic_piece !== 4'd4 || piece_read !== 4'd4) begin
         errors++;
         $display("FAIL capture_dst: got logic=%0d render=%0d expected 4", logic_piece, piece_read);
      end
      logic_x = 3; logic_y = 7; view_x = 3; view_y = 7; #1; checks++;
      if (logic_piece !== 4'd0 || piece_read !== 4'd0) begin
         errors++;
         $display("FAIL capture_src: got logic=%0d render=%0d expected 0", logic_piece, piece_read);
      end
   endtask

   task automatic test_ignore_busy();
      int n, d0;
      // Requests during the fill are dropped
      d0 = done_pulses;
      resetn = 1'b0;
      @(posedge clk); #1;
      resetn = 1'b1;
      src_x = 0; src_y = 1; dst_x = 0; dst_y = 3;
      repeat (10) @(posedge clk);
      #1;
      move_req = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      move_req = 1'b0;
      wait_ready(n);
      checks++;
      if (n > 40) begin errors++; $display("FAIL ignore_fill_len: got %0d expected 34", n); end
      checks++;
      if (done_pulses != d0) begin errors++; $display("FAIL ignore_fill_done: got %0d expected %0d", done_pulses, d0); end
      model_load_start();
      sweep_board("ignore_fill");
      // Requests held through a running move are dropped
      d0 = done_pulses;
      @(posedge clk); #1;
      src_x = 1; src_y = 6; dst_x = 1; dst_y = 5;
      move_req = 1'b1;
      @(posedge clk); #1;
      src_x = 6; src_y = 6; dst_x = 6; dst_y = 4;
      repeat (3) @(posedge clk);
      #1;
      move_req = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      checks++;
      if (done_pulses - d0 != 1) begin errors++; $display("FAIL ignore_busy_done: got %0d expected 1", done_pulses - d0); end
      model[1 + 5 * 8] = model[1 + 6 * 8];
      model[1 + 6 * 8] = 0;
      sweep_board("ignore_busy");
   endtask

   task automatic test_reset_mid_move();
      int n, d0;
      d0 = done_pulses;
      @(posedge clk); #1;
      src_x = 6; src_y = 7; dst_x = 6; dst_y = 0;
      move_req = 1'b1;
      @(posedge clk); #1;     // accepted
      move_req = 1'b0;
      @(posedge clk); #1;     // read done, now in the write step
      resetn = 1'b0;
      @(posedge clk); #1;
      resetn = 1'b1;
      checks++;
      if (ready !== 1'b0) begin errors++; $display("FAIL midmove_ready: got %0b expected 0", ready); end
      checks++;
      if (captured !== 4'd0) begin errors++; $display("FAIL midmove_captured: got %0d expected 0", captured); end
      wait_ready(n);
      checks++;
      if (n != 64) begin errors++; $display("FAIL midmove_fill_cycles: got %0d expected 64", n); end
      checks++;
      if (done_pulses != d0) begin errors++; $display("FAIL midmove_done: got %0d expected %0d", done_pulses, d0); end
      $display("reset mid-move fill cycles=%0d", n);
      model_load_start();
      sweep_board("midmove");
   endtask

   task automatic test_newgame_collision();
      int n, d0;
      run_move(7, 6, 7, 5);
      d0 = done_pulses;
      @(posedge clk); #1;
      src_x = 0; src_y = 6; dst_x = 0; dst_y = 5;
      new_game = 1'b1;
      move_req = 1'b1;
      @(posedge clk); #1;
      new_game = 1'b0;
      move_req = 1'b0;
      checks++;
      if (ready !== 1'b0) begin errors++; $display("FAIL newgame_ready: got %0b expected 0", ready); end
      wait_ready(n);
      checks++;
      if (n != 64) begin errors++; $display("FAIL newgame_fill_cycles: got %0d expected 64", n); end
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (done_pulses != d0) begin errors++; $display("FAIL newgame_done: got %0d expected %0d", done_pulses, d0); end
      $display("new_game fill cycles=%0d", n);
      model_load_start();
      sweep_board("newgame");
   endtask

   task automatic test_random_moves();
      int s, d;
      for (int t = 0; t < 25; t++) begin
         s = $urandom_range(0, 63);
         d = $urandom_range(0, 62);
         if (d >= s) d++;
         run_move(s % 8, s / 8, d % 8, d / 8);
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      done_pulses = 0;
      resetn = 1'b0;
      new_game = 1'b0;
      move_req = 1'b0;
      view_x = 0; view_y = 0; logic_x = 0; logic_y = 0;
      src_x = 0; src_y = 0; dst_x = 0; dst_y = 0;
      test_reset();
      test_quiet_move();
      test_capture();
      test_ignore_busy();
      test_reset_mid_move();
      test_newgame_collision();
      test_random_moves();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
